// File: rtl/control_pkg.sv
// control_pkg: opcode, step-state, IR field and ALU-line definitions shared by the control unit.
package control_pkg;

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    typedef enum logic [2:0] {C_ALU, C_MULDIV, C_UNARY, C_LD, C_ST, C_NOP, C_HALT, C_ILL} cls_t;

    localparam int SEL_W = 4;
    localparam int OP_HI = 31, OP_LO = 27;
    localparam int RA_HI = 26, RA_LO = 23;
    localparam int RB_HI = 22, RB_LO = 19;
    localparam int RC_HI = 18, RC_LO = 15;

    localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b00001, OP_ADD = 5'b00011, OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101, OP_SHL = 5'b00110, OP_ROR = 5'b00111, OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001, OP_OR = 5'b01010, OP_MUL = 5'b01110, OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000, OP_NOT = 5'b10001, OP_NOP = 5'b11000, OP_HALT = 5'b11011;

    // bit positions inside the datapath's alu_ctrl word, ADD at bit 0
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_MUL = 4'd2, A_DIV = 4'd3, A_SHR = 4'd4;
    localparam logic [3:0] A_SHL = 4'd5, A_ROR = 4'd6, A_ROL = 4'd7, A_AND = 4'd8, A_OR = 4'd9;
    localparam logic [3:0] A_NEG = 4'd10, A_NOT = 4'd11, A_INCPC = 4'd12;

    function automatic cls_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: return C_ALU;
            OP_MUL, OP_DIV: return C_MULDIV;
            OP_NEG, OP_NOT: return C_UNARY;
            OP_LD:   return C_LD;
            OP_ST:   return C_ST;
            OP_NOP:  return C_NOP;
            OP_HALT: return C_HALT;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_index(input logic [4:0] op);
        case (op)
            OP_SUB:  return A_SUB;
            OP_MUL:  return A_MUL;
            OP_DIV:  return A_DIV;
            OP_SHR:  return A_SHR;
            OP_SHL:  return A_SHL;
            OP_ROR:  return A_ROR;
            OP_ROL:  return A_ROL;
            OP_AND:  return A_AND;
            OP_OR:   return A_OR;
            OP_NEG:  return A_NEG;
            OP_NOT:  return A_NOT;
            default: return A_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decode.sv
// reg_select_decode: register number to one-hot select, all-zero when disabled.
module reg_select_decode
    import control_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     onehot
);
    assign onehot = en ? N'(1) << sel : '0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping fetch/decode/execute and
// driving every datapath strobe from the step state and the IR fields.
module control_sequencer
    import control_pkg::*;
#(
    parameter int BITS = 32,
    parameter int REGISTERS = 16,
    parameter int SIG_COUNT = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITS-1:0]      IRVal,
    input  logic                 mem_done,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, Read, MDRout, RZout, PCout,
    output logic INPUTout, OUTPUTin, HILOout, BAout,
    output logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
    output logic                 Write,
    output logic                 run,
    output logic                 illegal,
    output logic [BITS-1:0]      instr_count
);
    state_t state, next;
    cls_t cls;
    logic [4:0] op;
    logic [SEL_W-1:0] ra, rb, rc, in_sel, out_sel;
    logic in_en, out_en, done, unused_ir;
    logic [SIG_COUNT-1:0] alu;

    assign op = IRVal[OP_HI:OP_LO];
    assign ra = IRVal[RA_HI:RA_LO];
    assign rb = IRVal[RB_HI:RB_LO];
    assign rc = IRVal[RC_HI:RC_LO];
    assign cls = op_class(op);
    assign unused_ir = ^IRVal[RC_LO-1:0];
    assign run = state != IDLE && state != HALT;
    assign {INPUTout, OUTPUTin, HILOout, BAout} = '0;
    assign {IncPC, NOT, NEGATE, OR, AND, ROL, ROR, SHL, SHR, DIV, MUL, SUB, ADD} = alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            instr_count <= '0;
        end else begin
            state <= next;
            if (done) instr_count <= instr_count + BITS'(1);
        end
    end

    // IR fields are only consulted from T4 on, after IR has been loaded in T3
    always_comb begin
        next = state; done = 1'b0; illegal = 1'b0; Write = 1'b0; alu = '0;
        {PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, Read, MDRout, RZout, PCout} = '0;
        in_en = 1'b0; out_en = 1'b0; in_sel = ra; out_sel = rb;
        case (state)
            IDLE: next = start ? T0 : IDLE;
            T0: begin PCout = 1'b1; MARin = 1'b1; RZin = 1'b1; alu[A_INCPC] = 1'b1; next = T1; end
            T1: begin RZout = 1'b1; PCin = 1'b1; next = T2; end
            T2: begin Read = 1'b1; MDRin = 1'b1; next = mem_done ? T3 : T2; end
            T3: begin MDRout = 1'b1; IRin = 1'b1; next = T4; end
            T4: case (cls)
                C_ALU:    begin out_en = 1'b1; RYin = 1'b1; next = T5; end
                C_MULDIV: begin out_en = 1'b1; out_sel = ra; RYin = 1'b1; next = T5; end
                C_UNARY:  begin out_en = 1'b1; alu[alu_index(op)] = 1'b1; RZin = 1'b1; next = T5; end
                C_LD, C_ST: begin out_en = 1'b1; MARin = 1'b1; next = T5; end
                C_HALT:   next = HALT;
                C_ILL:    begin illegal = 1'b1; done = 1'b1; next = T0; end
                default:  begin done = 1'b1; next = T0; end
            endcase
            T5: case (cls)
                C_ALU:    begin out_en = 1'b1; out_sel = rc; alu[alu_index(op)] = 1'b1; RZin = 1'b1; next = T6; end
                C_MULDIV: begin out_en = 1'b1; alu[alu_index(op)] = 1'b1; RZin = 1'b1; next = T6; end
                C_UNARY:  begin RZout = 1'b1; in_en = 1'b1; done = 1'b1; next = T0; end
                C_LD:     begin Read = 1'b1; MDRin = 1'b1; next = mem_done ? T6 : T5; end
                C_ST:     begin out_en = 1'b1; out_sel = ra; MDRin = 1'b1; next = T6; end
                default:  next = T0;
            endcase
            T6: case (cls)
                C_ALU:    begin RZout = 1'b1; in_en = 1'b1; done = 1'b1; next = T0; end
                C_MULDIV: begin RZout = 1'b1; HILOin = 1'b1; done = 1'b1; next = T0; end
                C_LD:     begin MDRout = 1'b1; in_en = 1'b1; done = 1'b1; next = T0; end
                C_ST:     begin Write = 1'b1; done = mem_done; next = mem_done ? T0 : T6; end
                default:  next = T0;
            endcase
            HALT: next = HALT;
            default: next = IDLE;
        endcase
    end

    reg_select_decode #(.N(REGISTERS)) u_gpr_in  (.en(in_en),  .sel(in_sel),  .onehot(GPRin));
    reg_select_decode #(.N(REGISTERS)) u_gpr_out (.en(out_en), .sel(out_sel), .onehot(GPRout));
endmodule
